// File: rtl/traffic_pkg.sv
// Shared encodings, phase enumeration and phase durations for the intersection controller.
// Pure definitions; no latency or backpressure of its own.
package traffic_pkg;

  localparam logic [1:0] CAR_RED    = 2'b00;
  localparam logic [1:0] CAR_GREEN  = 2'b01;
  localparam logic [1:0] CAR_YELLOW = 2'b10;
  localparam logic [1:0] CAR_LEFT   = 2'b11;

  localparam logic [1:0] PED_RED   = 2'b00;
  localparam logic [1:0] PED_GREEN = 2'b01;
  localparam logic [1:0] PED_BLINK = 2'b10;

  localparam int unsigned DUR_GO   = 20;
  localparam int unsigned DUR_YEL  = 2;
  localparam int unsigned DUR_LEFT = 10;
  localparam int unsigned DUR_AR   = 2;

  // Walk stays solid green while the remaining count is at or above this value.
  localparam logic [5:0] PED_GREEN_MIN = 6'd6;

  typedef enum logic [3:0] {
    NS_GO    = 4'd0,
    NS_Y1    = 4'd1,
    NS_LEFT  = 4'd2,
    NS_Y2    = 4'd3,
    AR_NS    = 4'd4,
    EW_GO    = 4'd5,
    EW_Y1    = 4'd6,
    EW_LEFT  = 4'd7,
    EW_Y2    = 4'd8,
    AR_EW    = 4'd9,
    EMG_Y    = 4'd10,
    EMG_AR   = 4'd11,
    EMG_HOLD = 4'd12
  } phase_e;

  function automatic logic [5:0] phase_load(input phase_e p);
    case (p)
      NS_GO, EW_GO:                       phase_load = 6'(DUR_GO - 1);
      NS_LEFT, EW_LEFT:                   phase_load = 6'(DUR_LEFT - 1);
      NS_Y1, NS_Y2, EW_Y1, EW_Y2, EMG_Y:  phase_load = 6'(DUR_YEL - 1);
      AR_NS, AR_EW, EMG_AR:               phase_load = 6'(DUR_AR - 1);
      default:                            phase_load = 6'd0;
    endcase
  endfunction

  function automatic logic phase_axis(input phase_e p);
    phase_axis = (p == EW_GO) || (p == EW_Y1) || (p == EW_LEFT) ||
                 (p == EW_Y2) || (p == AR_EW);
  endfunction

  function automatic logic is_emg(input phase_e p);
    is_emg = (p == EMG_Y) || (p == EMG_AR) || (p == EMG_HOLD);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable saturating down-counter holding the remaining cycles of the current phase.
// Load takes effect on the next edge; hold freezes the count; never wraps below zero.
module phase_timer
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       hold,
  output logic [5:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 6'(DUR_AR - 1);
    end else if (load) begin
      count <= load_val;
    end else if (!hold && count != 6'd0) begin
      count <= count - 6'd1;
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-axis traffic phase scheduler with crosswalk/left-turn requests and emergency preemption.
// Outputs decode registered state in the same cycle; request pulses are latched, never dropped.
module traffic_phase_sched
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_ped_req,
  input  logic [1:0] i_left_req,
  input  logic       i_emg_req,
  input  logic       i_emg_axis,
  output logic [1:0] o_ns_car,
  output logic [1:0] o_ew_car,
  output logic [1:0] o_ns_ped,
  output logic [1:0] o_ew_ped,
  output logic [3:0] o_phase,
  output logic [5:0] o_timer,
  output logic       o_emg_active
);

  phase_e     state_q, state_d;
  logic [5:0] timer;
  logic [5:0] load_val;
  logic       enter, t_zero;
  logic [1:0] ped_q, left_q, ped_clr, left_clr;
  logic       grant_q, emg_axis_q, yel_axis_q;
  logic [1:0] ped_show;

  assign t_zero   = (timer == 6'd0);
  assign enter    = (state_d != state_q);
  assign load_val = phase_load(state_d);

  phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (enter),
    .load_val (load_val),
    .hold     (state_q == EMG_HOLD),
    .count    (timer)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GO:    if (i_emg_req) state_d = i_emg_axis ? EMG_Y : EMG_HOLD;
                else if (t_zero) state_d = NS_Y1;
      EW_GO:    if (i_emg_req) state_d = i_emg_axis ? EMG_HOLD : EMG_Y;
                else if (t_zero) state_d = EW_Y1;
      NS_LEFT:  if (i_emg_req) state_d = EMG_Y;
                else if (t_zero) state_d = NS_Y2;
      EW_LEFT:  if (i_emg_req) state_d = EMG_Y;
                else if (t_zero) state_d = EW_Y2;
      // Clearance phases always run to completion before preemption.
      NS_Y1:    if (t_zero) state_d = i_emg_req ? EMG_AR : (left_q[0] ? NS_LEFT : AR_NS);
      EW_Y1:    if (t_zero) state_d = i_emg_req ? EMG_AR : (left_q[1] ? EW_LEFT : AR_EW);
      NS_Y2:    if (t_zero) state_d = i_emg_req ? EMG_AR : AR_NS;
      EW_Y2:    if (t_zero) state_d = i_emg_req ? EMG_AR : AR_EW;
      AR_NS:    if (t_zero) state_d = i_emg_req ? EMG_AR : EW_GO;
      AR_EW:    if (t_zero) state_d = i_emg_req ? EMG_AR : NS_GO;
      EMG_Y:    if (t_zero) state_d = EMG_AR;
      EMG_AR:   if (t_zero) state_d = EMG_HOLD;
      EMG_HOLD: if (!i_emg_req) state_d = emg_axis_q ? EW_Y2 : NS_Y2;
      default:  state_d = AR_EW;
    endcase
  end

  assign ped_clr  = {enter && state_d == NS_GO,   enter && state_d == EW_GO};
  assign left_clr = {enter && state_d == EW_LEFT, enter && state_d == NS_LEFT};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AR_EW;
      ped_q      <= 2'b00;
      left_q     <= 2'b00;
      grant_q    <= 1'b0;
      emg_axis_q <= 1'b0;
      yel_axis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ped_q   <= (ped_q & ~ped_clr) | i_ped_req;
      left_q  <= (left_q & ~left_clr) | i_left_req;
      if (enter && state_d == NS_GO) grant_q <= ped_q[1];
      if (enter && state_d == EW_GO) grant_q <= ped_q[0];
      // Axis is frozen for the whole preemption once any EMG state is entered.
      if (enter && is_emg(state_d) && !is_emg(state_q)) emg_axis_q <= i_emg_axis;
      if (enter && state_d == EMG_Y) yel_axis_q <= phase_axis(state_q);
    end
  end

  assign ped_show = (timer >= PED_GREEN_MIN) ? PED_GREEN : PED_BLINK;

  always_comb begin
    o_ns_car = CAR_RED;
    o_ew_car = CAR_RED;
    o_ns_ped = PED_RED;
    o_ew_ped = PED_RED;
    case (state_q)
      NS_GO: begin
        o_ns_car = CAR_GREEN;
        if (grant_q) o_ew_ped = ped_show;
      end
      EW_GO: begin
        o_ew_car = CAR_GREEN;
        if (grant_q) o_ns_ped = ped_show;
      end
      NS_Y1, NS_Y2: o_ns_car = CAR_YELLOW;
      EW_Y1, EW_Y2: o_ew_car = CAR_YELLOW;
      NS_LEFT:      o_ns_car = CAR_LEFT;
      EW_LEFT:      o_ew_car = CAR_LEFT;
      EMG_Y:        if (yel_axis_q) o_ew_car = CAR_YELLOW; else o_ns_car = CAR_YELLOW;
      EMG_HOLD:     if (emg_axis_q) o_ew_car = CAR_GREEN;  else o_ns_car = CAR_GREEN;
      default: ;
    endcase
  end

  assign o_phase      = state_q;
  assign o_timer      = timer;
  assign o_emg_active = is_emg(state_q);

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for the traffic phase scheduler: walks hand-timed phase sequences and
// compares every output each cycle against values derived from the phase table.
module tb_traffic_phase_sched;
  import traffic_pkg::*;

  localparam logic [1:0] C_R = 2'b00;
  localparam logic [1:0] C_G = 2'b01;
  localparam logic [1:0] C_Y = 2'b10;
  localparam logic [1:0] C_L = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] i_ped_req, i_left_req;
  logic       i_emg_req, i_emg_axis;
  logic [1:0] o_ns_car, o_ew_car, o_ns_ped, o_ew_ped;
  logic [3:0] o_phase;
  logic [5:0] o_timer;
  logic       o_emg_active;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  traffic_phase_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ped_req    (i_ped_req),
    .i_left_req   (i_left_req),
    .i_emg_req    (i_emg_req),
    .i_emg_axis   (i_emg_axis),
    .o_ns_car     (o_ns_car),
    .o_ew_car     (o_ew_car),
    .o_ns_ped     (o_ns_ped),
    .o_ew_ped     (o_ew_ped),
    .o_phase      (o_phase),
    .o_timer      (o_timer),
    .o_emg_active (o_emg_active)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Walk signal for a crosswalk: red unless granted, green at >=6 left, blink for the last 6.
  function automatic logic [1:0] ped_exp(input logic granted, input logic [5:0] t);
    if (!granted) return 2'b00;
    return (t >= 6'd6) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string tag, input phase_e ph, input logic [5:0] t,
                     input logic [1:0] nc, input logic [1:0] ec,
                     input logic [1:0] np, input logic [1:0] ep, input logic emg);
    logic [18:0] got, exp;
    got = {o_phase, o_timer, o_ns_car, o_ew_car, o_ns_ped, o_ew_ped, o_emg_active};
    exp = {ph, t, nc, ec, np, ep, emg};
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cyc=%0d: observed {ph,tmr,nsc,ewc,nsp,ewp,emg}=%h required %h",
                tag, cyc, got, exp);
  endtask

  // Checks ncyc cycles of a phase of length dur; optional request pulses in its first cycle.
  task automatic run_phase(input string tag, input phase_e ph, input int dur, input int ncyc,
                           input logic [1:0] nc, input logic [1:0] ec,
                           input logic ns_pm, input logic ew_pm,
                           input logic [1:0] ped_p, input logic [1:0] left_p);
    logic [5:0] t;
    logic       emg;
    emg = (ph == EMG_Y) || (ph == EMG_AR) || (ph == EMG_HOLD);
    for (int k = 0; k < ncyc; k++) begin
      t = 6'(dur - 1 - k);
      chk(tag, ph, t, nc, ec, ped_exp(ns_pm, t), ped_exp(ew_pm, t), emg);
      if (k == 0) begin
        i_ped_req  = ped_p;
        i_left_req = left_p;
      end
      tick();
      i_ped_req  = 2'b00;
      i_left_req = 2'b00;
    end
  endtask

  initial begin
    i_ped_req  = 2'b00;
    i_left_req = 2'b00;
    i_emg_req  = 1'b0;
    i_emg_axis = 1'b0;

    #12;
    chk("reset_hold", AR_EW, 6'd1, C_R, C_R, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 1;

    // Boot cycle with no requests: EW_GO must start at cycle 27.
    run_phase("boot_ar",  AR_EW, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ns_go0",   NS_GO, 20, 20, C_G, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ns_y1_0",  NS_Y1, 2, 2,  C_Y, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ar_ns0",   AR_NS, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ew_go0",   EW_GO, 20, 20, C_R, C_G, 0, 0, 2'b00, 2'b00);
    run_phase("ew_y1_0",  EW_Y1, 2, 2,  C_R, C_Y, 0, 0, 2'b00, 2'b00);

    // EW crosswalk request in AR_EW, NS left request during NS_GO.
    run_phase("ar_ew_ped", AR_EW, 2, 2,  C_R, C_R, 0, 0, 2'b10, 2'b00);
    run_phase("ns_go_ped", NS_GO, 20, 20, C_G, C_R, 0, 1, 2'b00, 2'b01);
    run_phase("ns_y1_l",   NS_Y1, 2, 2,  C_Y, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ns_left",   NS_LEFT, 10, 10, C_L, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ns_y2",     NS_Y2, 2, 2,  C_Y, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ar_ns_l",   AR_NS, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ew_go1",    EW_GO, 20, 20, C_R, C_G, 0, 0, 2'b00, 2'b00);
    run_phase("ew_y1_1",   EW_Y1, 2, 2,  C_R, C_Y, 0, 0, 2'b00, 2'b00);
    run_phase("ar_ew1",    AR_EW, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ns_go_clr", NS_GO, 20, 20, C_G, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ns_y1_skp", NS_Y1, 2, 2,  C_Y, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ar_ns_skp", AR_NS, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("ew_go2",    EW_GO, 20, 20, C_R, C_G, 0, 0, 2'b00, 2'b00);
    run_phase("ew_y1_2",   EW_Y1, 2, 2,  C_R, C_Y, 0, 0, 2'b00, 2'b00);
    run_phase("ar_ew2",    AR_EW, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);

    // Cross-axis emergency raised at NS_GO timer=10.
    run_phase("ns_go_pre", NS_GO, 20, 9, C_G, C_R, 0, 0, 2'b00, 2'b00);
    chk("emg_arm", NS_GO, 6'd10, C_G, C_R, 2'b00, 2'b00, 1'b0);
    i_emg_req  = 1'b1;
    i_emg_axis = 1'b1;
    tick();
    run_phase("emg_y",  EMG_Y, 2, 2,  C_Y, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("emg_ar", EMG_AR, 2, 2, C_R, C_R, 0, 0, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      chk("emg_hold_ew", EMG_HOLD, 6'd0, C_R, C_G, 2'b00, 2'b00, 1'b1);
      i_emg_axis = 1'b0;
      tick();
    end
    chk("emg_hold_last", EMG_HOLD, 6'd0, C_R, C_G, 2'b00, 2'b00, 1'b1);
    i_emg_req = 1'b0;
    tick();
    run_phase("emg_ew_y2", EW_Y2, 2, 2, C_R, C_Y, 0, 0, 2'b00, 2'b00);
    run_phase("emg_ar_ew", AR_EW, 2, 2, C_R, C_R, 0, 0, 2'b10, 2'b00);

    // Same-axis emergency while the EW crosswalk is walking: straight to hold.
    run_phase("ns_go_walk", NS_GO, 20, 5, C_G, C_R, 0, 1, 2'b00, 2'b00);
    chk("emg_same_arm", NS_GO, 6'd14, C_G, C_R, 2'b00, 2'b01, 1'b0);
    i_emg_req  = 1'b1;
    i_emg_axis = 1'b0;
    tick();
    chk("emg_same_hold", EMG_HOLD, 6'd0, C_G, C_R, 2'b00, 2'b00, 1'b1);
    i_ped_req  = 2'b10;
    i_left_req = 2'b01;
    tick();
    i_ped_req  = 2'b00;
    i_left_req = 2'b00;
    chk("emg_same_hold2", EMG_HOLD, 6'd0, C_G, C_R, 2'b00, 2'b00, 1'b1);

    // Asynchronous reset in the middle of the hold cycle.
    #2;
    rst_n     = 1'b0;
    i_emg_req = 1'b0;
    #1;
    chk("rst_async", AR_EW, 6'd1, C_R, C_R, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 1;
    run_phase("rst_ar",     AR_EW, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("rst_ns_go",  NS_GO, 20, 20, C_G, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("rst_ns_y1",  NS_Y1, 2, 2,  C_Y, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("rst_ar_ns",  AR_NS, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    run_phase("rst_ew_go",  EW_GO, 20, 20, C_R, C_G, 0, 0, 2'b00, 2'b00);

    // Emergency during yellow: yellow completes, then EMG_AR; early drop gives a 1-cycle hold.
    i_emg_req  = 1'b1;
    i_emg_axis = 1'b1;
    run_phase("y1_emg",     EW_Y1, 2, 2,  C_R, C_Y, 0, 0, 2'b00, 2'b00);
    i_emg_req = 1'b0;
    run_phase("y1_emg_ar",  EMG_AR, 2, 2, C_R, C_R, 0, 0, 2'b00, 2'b00);
    chk("hold_1cyc", EMG_HOLD, 6'd0, C_R, C_G, 2'b00, 2'b00, 1'b1);
    tick();
    run_phase("exit_ew_y2", EW_Y2, 2, 2,  C_R, C_Y, 0, 0, 2'b00, 2'b00);
    run_phase("exit_ar_ew", AR_EW, 2, 2,  C_R, C_R, 0, 0, 2'b00, 2'b00);
    chk("exit_ns_go", NS_GO, 6'd19, C_G, C_R, 2'b00, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
